// File: rtl/team_06_voice_ctrl.sv
// Voice channel controller: debounced buttons, effect select,
// push-to-talk / noise-gate FSM with hang time.
module team_06_voice_ctrl #(
    parameter int AUD_W       = 8,
    parameter int GATE_THRESH = 64,
    parameter int NUM_EFF     = 5,
    parameter int DB_CYC      = 4,
    parameter int HANG_CYC    = 1024,
    localparam int EFF_W      = (NUM_EFF > 1) ? $clog2(NUM_EFF) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AUD_W-1:0] mic_aud,
    input  logic [AUD_W-1:0] spk_aud,
    input  logic             ptt_btn,
    input  logic             ng_btn,
    input  logic             mute_btn,
    input  logic             eff_up_btn,
    input  logic             eff_dn_btn,
    output logic [1:0]       state,
    output logic             talk,
    output logic             vol_en,
    output logic             eff_en,
    output logic [EFF_W-1:0] cur_eff,
    output logic             mute_on,
    output logic             gate_on
);

    localparam logic [1:0] LIST = 2'b00;
    localparam logic [1:0] TALK = 2'b01;
    localparam logic [1:0] HANG = 2'b10;

    localparam int DW = $clog2(DB_CYC + 1);
    localparam int HW = (HANG_CYC > 1) ? $clog2(HANG_CYC) : 1;

    localparam logic [DW-1:0]    DB_LAST = DW'(DB_CYC - 1);
    localparam logic [HW-1:0]    HANG_LD = HW'(HANG_CYC - 1);
    localparam logic [EFF_W-1:0] EFF_MAX = EFF_W'(NUM_EFF - 1);
    localparam logic [AUD_W-1:0] THRESH  = AUD_W'(GATE_THRESH);

    // bit 0 ptt, 1 ng, 2 mute, 3 up, 4 down
    logic [4:0]    raw;
    logic [4:0]    lvl;
    logic [4:0]    press;
    logic [DW-1:0] cnt [5];

    logic [1:0]    cur_st;
    logic [1:0]    nxt_st;
    logic [HW-1:0] hang;
    logic [HW-1:0] nxt_hang;

    logic above;
    logic spk_active;
    logic req;

    assign raw = {eff_dn_btn, eff_up_btn, mute_btn, ng_btn, ptt_btn};

    // Debounce each button; press pulses one cycle on a rising flip
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl   <= '0;
            press <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                press[i] <= 1'b0;
                if (raw[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    cnt[i]   <= '0;
                    lvl[i]   <= ~lvl[i];
                    press[i] <= ~lvl[i];
                end else begin
                    cnt[i] <= cnt[i] + DW'(1);
                end
            end
        end
    end

    // Toggle settings and step the effect index on press pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mute_on <= 1'b0;
            gate_on <= 1'b0;
            cur_eff <= '0;
        end else begin
            if (press[2]) mute_on <= ~mute_on;
            if (press[1]) gate_on <= ~gate_on;
            case ({press[3], press[4]})
                2'b10: cur_eff <= (cur_eff == EFF_MAX) ? '0 : cur_eff + EFF_W'(1);
                2'b01: cur_eff <= (cur_eff == '0) ? EFF_MAX : cur_eff - EFF_W'(1);
                default: cur_eff <= cur_eff;
            endcase
        end
    end

    assign above      = (mic_aud >= THRESH);
    assign spk_active = (spk_aud != '0);
    assign req        = lvl[0] | (gate_on & above);

    // State register and hang counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_st <= LIST;
            hang   <= '0;
        end else begin
            cur_st <= nxt_st;
            hang   <= nxt_hang;
        end
    end

    // Next state: received audio always wins, then talk requests
    always_comb begin
        nxt_st   = LIST;
        nxt_hang = '0;
        case (cur_st)
            LIST: begin
                if (!spk_active && req) nxt_st = TALK;
            end
            TALK: begin
                if (spk_active) begin
                    nxt_st = LIST;
                end else if (req) begin
                    nxt_st = TALK;
                end else if (gate_on) begin
                    nxt_st   = HANG;
                    nxt_hang = HANG_LD;
                end
            end
            HANG: begin
                if (spk_active) begin
                    nxt_st = LIST;
                end else if (req) begin
                    nxt_st = TALK;
                end else if (gate_on && hang != '0) begin
                    nxt_st   = HANG;
                    nxt_hang = hang - HW'(1);
                end
            end
            default: nxt_st = LIST;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        state  = cur_st;
        talk   = (cur_st == TALK) || (cur_st == HANG);
        vol_en = (cur_st == LIST) && !mute_on;
        eff_en = talk && (cur_eff != '0);
    end

endmodule

// File: tb/tb_team_06_voice_ctrl.sv
// Directed bench for team_06_voice_ctrl with
// DB_CYC=4, HANG_CYC=8, NUM_EFF=5, GATE_THRESH=64.
module tb_team_06_voice_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] mic_aud;
    logic [7:0] spk_aud;
    logic       ptt_btn;
    logic       ng_btn;
    logic       mute_btn;
    logic       eff_up_btn;
    logic       eff_dn_btn;
    logic [1:0] state;
    logic       talk;
    logic       vol_en;
    logic       eff_en;
    logic [2:0] cur_eff;
    logic       mute_on;
    logic       gate_on;

    int total = 0;
    int bad   = 0;

    team_06_voice_ctrl #(
        .AUD_W(8),
        .GATE_THRESH(64),
        .NUM_EFF(5),
        .DB_CYC(4),
        .HANG_CYC(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mic_aud(mic_aud),
        .spk_aud(spk_aud),
        .ptt_btn(ptt_btn),
        .ng_btn(ng_btn),
        .mute_btn(mute_btn),
        .eff_up_btn(eff_up_btn),
        .eff_dn_btn(eff_dn_btn),
        .state(state),
        .talk(talk),
        .vol_en(vol_en),
        .eff_en(eff_en),
        .cur_eff(cur_eff),
        .mute_on(mute_on),
        .gate_on(gate_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: eff_up_btn = v;
            1: eff_dn_btn = v;
            2: begin eff_up_btn = v; eff_dn_btn = v; end
            3: mute_btn = v;
            default: ng_btn = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        repeat (5) step();
        set_btn(b, 1'b0);
        repeat (4) step();
    endtask

    initial begin
        rst = 1'b0;
        mic_aud = 8'd0;
        spk_aud = 8'd0;
        ptt_btn = 1'b0;
        ng_btn = 1'b0;
        mute_btn = 1'b0;
        eff_up_btn = 1'b0;
        eff_dn_btn = 1'b0;
        #3;
        chk("rst_state", state, 2'b00);
        chk("rst_talk", talk, 1'b0);
        chk("rst_vol", vol_en, 1'b1);
        chk("rst_eff_en", eff_en, 1'b0);
        chk("rst_cur_eff", cur_eff, 3'd0);
        chk("rst_mute", mute_on, 1'b0);
        chk("rst_gate", gate_on, 1'b0);
        step();
        rst = 1'b1;

        // ptt glitch of 3 edges does nothing
        ptt_btn = 1'b1;
        repeat (3) step();
        ptt_btn = 1'b0;
        repeat (2) step();
        chk("ptt_short", state, 2'b00);

        // ptt held: debounced on 4th edge, TALK on 5th
        ptt_btn = 1'b1;
        repeat (4) step();
        chk("ptt_edge4", state, 2'b00);
        step();
        chk("ptt_edge5", state, 2'b01);
        chk("ptt_talk", talk, 1'b1);
        chk("ptt_vol", vol_en, 1'b0);
        spk_aud = 8'd1;
        step();
        chk("spk_prio", state, 2'b00);
        spk_aud = 8'd0;
        ptt_btn = 1'b0;
        repeat (6) step();
        chk("ptt_off", state, 2'b00);

        // noise gate on: toggle on 5th edge
        ng_btn = 1'b1;
        repeat (4) step();
        chk("ng_edge4", gate_on, 1'b0);
        step();
        chk("ng_edge5", gate_on, 1'b1);
        ng_btn = 1'b0;
        repeat (4) step();
        chk("ng_release", gate_on, 1'b1);

        // gate threshold and hang dwell
        mic_aud = 8'd64;
        step();
        chk("gate_64", state, 2'b01);
        mic_aud = 8'd63;
        step();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("hang_%0d", i), state, 2'b10);
            step();
        end
        chk("hang_done", state, 2'b00);

        // activity mid-hang returns to TALK
        mic_aud = 8'd64;
        step();
        mic_aud = 8'd63;
        step();
        repeat (4) step();
        chk("hang_mid", state, 2'b10);
        mic_aud = 8'd100;
        step();
        chk("hang_retalk", state, 2'b01);
        chk("talk_eff0", eff_en, 1'b0);
        mic_aud = 8'd0;
        step();
        chk("hang_reenter", state, 2'b10);
        repeat (7) step();
        chk("hang_reload", state, 2'b10);
        step();
        chk("hang_end2", state, 2'b00);

        // mute in LIST
        mute_btn = 1'b1;
        repeat (4) step();
        chk("mute_e4", vol_en, 1'b1);
        step();
        chk("mute_e5", vol_en, 1'b0);
        mute_btn = 1'b0;
        repeat (4) step();
        press(3);
        chk("mute_off", vol_en, 1'b1);

        // effect stepping
        for (int i = 0; i < 5; i++) begin
            press(0);
            chk($sformatf("eff_up_%0d", i), cur_eff, (i + 1) % 5);
        end
        press(1);
        chk("eff_dn_wrap", cur_eff, 3'd4);
        press(2);
        chk("eff_both", cur_eff, 3'd4);

        // TALK with effect selected
        mic_aud = 8'd100;
        step();
        chk("eff_talk", state, 2'b01);
        chk("eff_en_on", eff_en, 1'b1);
        chk("talk_vol", vol_en, 1'b0);
        press(1);
        chk("eff_dn3", cur_eff, 3'd3);
        press(3);
        chk("mute_talk", mute_on, 1'b1);
        chk("mute_talk_vol", vol_en, 1'b0);

        // reset in the middle of HANG
        mic_aud = 8'd0;
        step();
        step();
        chk("pre_rst_hang", state, 2'b10);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_state", state, 2'b00);
        chk("arst_eff", cur_eff, 3'd0);
        chk("arst_mute", mute_on, 1'b0);
        chk("arst_vol", vol_en, 1'b1);
        chk("arst_talk", talk, 1'b0);
        chk("arst_gate", gate_on, 1'b0);

        // button held through reset release
        mute_btn = 1'b1;
        step();
        rst = 1'b1;
        repeat (4) step();
        chk("held_e4", mute_on, 1'b0);
        step();
        chk("held_e5", mute_on, 1'b1);
        mute_btn = 1'b0;
        repeat (4) step();

        // ng glitches never toggle the gate
        for (int i = 0; i < 5; i++) begin
            ng_btn = 1'b1;
            repeat (3) step();
            ng_btn = 1'b0;
            step();
        end
        repeat (2) step();
        chk("ng_glitch", gate_on, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/team_06_voice_ctrl.md
TEAM_06_VOICE_CTRL -- requirements
Module: team_06_voice_ctrl

Interface
REQ-001 SHALL have parameter AUD_W, default 8, audio sample width (unsigned).
REQ-002 SHALL have parameter GATE_THRESH, default 64, noise-gate open threshold (AUD_W bits).
REQ-003 SHALL have parameter NUM_EFF, default 5, effect count (index 0 = NORMAL); EFF_W = max(1, clog2(NUM_EFF)).
REQ-004 SHALL have parameter DB_CYC, default 4, debounce stable-cycle count, >= 1.
REQ-005 SHALL have parameter HANG_CYC, default 1024, gate hang time in cycles, >= 1.
REQ-006 SHALL have port clk, input, 1, single clock, rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port mic_aud, input, AUD_W, live mic sample.
REQ-009 SHALL have port spk_aud, input, AUD_W, live received sample.
REQ-010 SHALL have port ptt_btn, input, 1, raw push-to-talk level.
REQ-011 SHALL have port ng_btn, input, 1, raw noise-gate toggle button.
REQ-012 SHALL have port mute_btn, input, 1, raw mute toggle button.
REQ-013 SHALL have port eff_up_btn, input, 1, raw next-effect button.
REQ-014 SHALL have port eff_dn_btn, input, 1, raw previous-effect button.
REQ-015 SHALL have port state, output, 2, LIST=00, TALK=01, HANG=10.
REQ-016 SHALL have port talk, output, 1, high in TALK or HANG.
REQ-017 SHALL have port vol_en, output, 1, speaker volume enable.
REQ-018 SHALL have port eff_en, output, 1, effect path enable.
REQ-019 SHALL have port cur_eff, output, EFF_W, selected effect index.
REQ-020 SHALL have port mute_on, output, 1, mute toggle state.
REQ-021 SHALL have port gate_on, output, 1, noise-gate toggle state.

Function
REQ-022 Each of the five buttons SHALL have an independent debouncer: counter of consecutive edges where raw != debounced level; any edge with raw == debounced clears it; debounced level flips on the DB_CYC-th consecutive differing edge.
REQ-023 Press pulse SHALL be one cycle on debounced rising edge; release produces no pulse.
REQ-024 mute_on / gate_on SHALL toggle on the edge after their press pulse (raw-stable to toggle = DB_CYC+1 edges).
REQ-025 cur_eff SHALL increment on up press, wrapping NUM_EFF-1 -> 0, and decrement on down press, wrapping 0 -> NUM_EFF-1; simultaneous up and down pulses SHALL leave cur_eff unchanged.
REQ-026 above = (mic_aud >= GATE_THRESH); spk_active = (spk_aud != 0); ptt = debounced ptt_btn level.
REQ-027 LIST: spk_active -> LIST; else ptt or (gate_on and above) -> TALK; else LIST.
REQ-028 TALK: spk_active -> LIST; else ptt or (gate_on and above) -> TALK; else gate_on -> HANG with hang counter loaded to HANG_CYC-1; else -> LIST.
REQ-029 HANG: spk_active -> LIST; else ptt or (gate_on and above) -> TALK; else !gate_on -> LIST; else counter == 0 -> LIST; else stay, counter decrements.
REQ-030 Re-entry to HANG SHALL always reload the counter; HANG dwell with no activity SHALL be exactly HANG_CYC cycles.
REQ-031 spk_active SHALL take priority over all talk requests in every state.
REQ-032 vol_en SHALL be high iff state == LIST and mute_on == 0.
REQ-033 eff_en SHALL be high iff talk == 1 and cur_eff != 0.
REQ-034 All outputs SHALL be registered state or combinational decode of registered state only; no combinational path from audio or button inputs to outputs.
REQ-035 Encoding 11 SHALL recover to LIST on the next edge.

Reset
REQ-036 Asserting rst low SHALL immediately force state=LIST, cur_eff=0, mute_on=0, gate_on=0, hang counter=0, debounced levels=0, debounce counters=0, regardless of current state (including mid-HANG).
REQ-037 Outputs during reset SHALL be: talk=0, vol_en=1, eff_en=0.
REQ-038 A button held high through reset release SHALL register one press after DB_CYC edges.

Verification (DB_CYC=4, HANG_CYC=8, NUM_EFF=5, GATE_THRESH=64)
REQ-039 ptt_btn high 3 edges then low -> no TALK; held 4 edges -> state=01 on 5th edge; spk_aud=1 while held -> state=00 next edge.
REQ-040 gate_on=1, mic_aud=64 -> TALK; mic_aud=63 -> HANG for exactly 8 cycles then LIST; mic_aud=100 at hang cycle 5 -> TALK.
REQ-041 eff_up pressed 5 times -> cur_eff 1,2,3,4,0; eff_dn from 0 -> 4; both pressed same edge -> unchanged.
REQ-042 mute press in LIST -> vol_en 1->0 after 5 edges; second press -> vol_en=1; in TALK vol_en=0 regardless.
REQ-043 rst low during HANG with cur_eff=3, mute_on=1 -> state=00, cur_eff=0, mute_on=0, vol_en=1 immediately, before next edge.
REQ-044 ng_btn 1-cycle glitches (DB_CYC-1 high, 1 low, repeat) -> gate_on never toggles.
